ppu_host_regs: RTL and testbench

- Host-side register bank of the PPU, at CPU offsets 0..7.
- Decodes host reads and writes. Holds CTRL, MASK, OAMADDR, scroll/address state (v, t, fine_x, w), the PPUDATA read buffer, the open-bus latch, the status flags and NMI generation.
- Sits directly upstream of the video pipeline. It supplies control and scroll state to rendering and sequences host access to OAM and the cart/VRAM bus.

---
 rtl/ppu_host_regs.sv | 222 ++++++++++++++++++++++
 tb/tb_ppu_host_regs.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_host_regs.sv
`default_nettype none
// ============================================================================
// Module   : ppu_host_regs
// Purpose  : PPU host register bank (CPU offsets 0..7): CTRL/MASK/OAM/scroll,
//            buffered VRAM data port, status flags and NMI generation.
// Revision : 1.0 - initial release
// ============================================================================
module ppu_host_regs #(
    parameter int P_vaddr_bits = 15,
    parameter int P_vram_bits  = 14
) (
    input  logic                    I_clock,
    input  logic                    I_reset,
    input  logic [2:0]              I_host_addr,
    input  logic                    I_host_wren,
    input  logic                    I_host_rden,
    input  logic [7:0]              I_host_data,
    output logic [7:0]              O_host_data,
    output logic                    O_host_nmi,
    input  logic                    I_vblank_set,
    input  logic                    I_vblank_clear,
    input  logic                    I_spr0_hit,
    input  logic                    I_spr_ovf,
    output logic [7:0]              O_ctrl,
    output logic [7:0]              O_mask,
    output logic [P_vaddr_bits-1:0] O_taddr,
    output logic [P_vaddr_bits-1:0] O_vaddr,
    output logic [2:0]              O_fine_x,
    output logic [7:0]              O_oam_addr,
    output logic                    O_oam_wren,
    output logic [7:0]              O_oam_data,
    input  logic [7:0]              I_oam_data,
    output logic [P_vram_bits-1:0]  O_vram_addr,
    output logic                    O_vram_wren,
    output logic                    O_vram_rden,
    output logic [7:0]              O_vram_data,
    input  logic [7:0]              I_vram_data
);

    localparam logic [2:0] c_REG_CTRL    = 3'd0;
    localparam logic [2:0] c_REG_MASK    = 3'd1;
    localparam logic [2:0] c_REG_STATUS  = 3'd2;
    localparam logic [2:0] c_REG_OAMADDR = 3'd3;
    localparam logic [2:0] c_REG_OAMDATA = 3'd4;
    localparam logic [2:0] c_REG_SCROLL  = 3'd5;
    localparam logic [2:0] c_REG_ADDR    = 3'd6;
    localparam logic [2:0] c_REG_DATA    = 3'd7;

    logic [7:0]              r_ctrl;
    logic [7:0]              r_mask;
    logic [P_vaddr_bits-1:0] r_t;
    logic [P_vaddr_bits-1:0] r_v;
    logic [2:0]              r_fine_x;
    logic                    r_w;
    logic [7:0]              r_oam_addr;
    logic [7:0]              r_buf;
    logic                    r_fill;
    logic [7:0]              r_latch;
    logic [7:0]              r_host_data;
    logic                    r_vblank;
    logic                    r_spr0;
    logic                    r_ovf;
    logic                    r_nmi;

    logic                    w_wr;
    logic                    w_rd;
    logic                    w_wr_ctrl;
    logic                    w_wr_mask;
    logic                    w_wr_oamaddr;
    logic                    w_wr_oamdata;
    logic                    w_wr_scroll;
    logic                    w_wr_addr;
    logic                    w_wr_data;
    logic                    w_rd_status;
    logic                    w_rd_data;
    logic [7:0]              w_rd_val;
    logic [7:0]              w_ctrl_nxt;
    logic                    w_vblank_nxt;
    logic                    w_spr0_nxt;
    logic                    w_ovf_nxt;
    logic [P_vaddr_bits-1:0] w_v_inc;
    logic [P_vaddr_bits-1:0] w_t_full;

    // A simultaneous write and read is treated as the write alone.
    assign w_wr         = I_host_wren;
    assign w_rd         = I_host_rden & ~I_host_wren;
    assign w_wr_ctrl    = w_wr & (I_host_addr == c_REG_CTRL);
    assign w_wr_mask    = w_wr & (I_host_addr == c_REG_MASK);
    assign w_wr_oamaddr = w_wr & (I_host_addr == c_REG_OAMADDR);
    assign w_wr_oamdata = w_wr & (I_host_addr == c_REG_OAMDATA);
    assign w_wr_scroll  = w_wr & (I_host_addr == c_REG_SCROLL);
    assign w_wr_addr    = w_wr & (I_host_addr == c_REG_ADDR);
    assign w_wr_data    = w_wr & (I_host_addr == c_REG_DATA);
    assign w_rd_status  = w_rd & (I_host_addr == c_REG_STATUS);
    assign w_rd_data    = w_rd & (I_host_addr == c_REG_DATA);

    assign w_ctrl_nxt = w_wr_ctrl ? I_host_data : r_ctrl;
    assign w_v_inc    = r_ctrl[2] ? P_vaddr_bits'(32) : P_vaddr_bits'(1);
    assign w_t_full   = {r_t[P_vaddr_bits-1:8], I_host_data};

    // A fill landing this cycle is forwarded straight to a back-to-back read.
    always_comb begin
        case (I_host_addr)
            c_REG_STATUS:  w_rd_val = {r_vblank & ~I_vblank_set, r_spr0, r_ovf, r_latch[4:0]};
            c_REG_OAMDATA: w_rd_val = I_oam_data;
            c_REG_DATA:    w_rd_val = r_fill ? I_vram_data : r_buf;
            default:       w_rd_val = r_latch;
        endcase
    end

    always_comb begin
        w_vblank_nxt = r_vblank;
        w_spr0_nxt   = r_spr0 | I_spr0_hit;
        w_ovf_nxt    = r_ovf | I_spr_ovf;
        if (I_vblank_set) begin
            w_vblank_nxt = 1'b1;
        end
        if (w_rd_status) begin
            w_vblank_nxt = 1'b0;
        end
        if (I_vblank_clear) begin
            w_vblank_nxt = 1'b0;
            w_spr0_nxt   = 1'b0;
            w_ovf_nxt    = 1'b0;
        end
    end

    always_ff @(posedge I_clock) begin
        if (!I_reset) begin
            r_ctrl      <= '0;
            r_mask      <= '0;
            r_t         <= '0;
            r_v         <= '0;
            r_fine_x    <= '0;
            r_w         <= 1'b0;
            r_oam_addr  <= '0;
            r_buf       <= '0;
            r_fill      <= 1'b0;
            r_latch     <= '0;
            r_host_data <= '0;
            r_vblank    <= 1'b0;
            r_spr0      <= 1'b0;
            r_ovf       <= 1'b0;
            r_nmi       <= 1'b0;
        end else begin
            r_ctrl   <= w_ctrl_nxt;
            r_vblank <= w_vblank_nxt;
            r_spr0   <= w_spr0_nxt;
            r_ovf    <= w_ovf_nxt;
            r_nmi    <= w_ctrl_nxt[7] & w_vblank_nxt;
            r_fill   <= w_rd_data;
            if (r_fill) begin
                r_buf <= I_vram_data;
            end
            if (w_wr) begin
                r_latch <= I_host_data;
            end
            if (w_rd) begin
                r_latch     <= w_rd_val;
                r_host_data <= w_rd_val;
            end
            if (w_wr_ctrl) begin
                r_t[11:10] <= I_host_data[1:0];
            end
            if (w_wr_mask) begin
                r_mask <= I_host_data;
            end
            if (w_wr_oamaddr) begin
                r_oam_addr <= I_host_data;
            end
            if (w_wr_oamdata) begin
                r_oam_addr <= r_oam_addr + 8'd1;
            end
            if (w_rd_status) begin
                r_w <= 1'b0;
            end
            if (w_wr_scroll) begin
                if (!r_w) begin
                    r_t[4:0] <= I_host_data[7:3];
                    r_fine_x <= I_host_data[2:0];
                end else begin
                    r_t[14:12] <= I_host_data[2:0];
                    r_t[9:5]   <= I_host_data[7:3];
                end
                r_w <= ~r_w;
            end
            if (w_wr_addr) begin
                if (!r_w) begin
                    r_t[13:8] <= I_host_data[5:0];
                    r_t[14]   <= 1'b0;
                end else begin
                    r_t[7:0] <= I_host_data;
                    r_v      <= w_t_full;
                end
                r_w <= ~r_w;
            end
            if (w_wr_data | w_rd_data) begin
                r_v <= r_v + w_v_inc;
            end
        end
    end

    // Bus strobes are decoded directly from the host access so they coincide
    // with the address currently held in v / oam_addr.
    assign O_oam_wren  = I_reset & w_wr_oamdata;
    assign O_oam_data  = I_host_data;
    assign O_vram_wren = I_reset & w_wr_data;
    assign O_vram_rden = I_reset & w_rd_data;
    assign O_vram_data = I_host_data;
    assign O_vram_addr = r_v[P_vram_bits-1:0];

    assign O_host_data = r_host_data;
    assign O_host_nmi  = r_nmi;
    assign O_ctrl      = r_ctrl;
    assign O_mask      = r_mask;
    assign O_taddr     = r_t;
    assign O_vaddr     = r_v;
    assign O_fine_x    = r_fine_x;
    assign O_oam_addr  = r_oam_addr;

endmodule
`default_nettype wire

// File: tb/tb_ppu_host_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_host_regs
// Purpose  : Self-checking bench for ppu_host_regs with a host-read scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_host_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  host_addr;
    logic        host_wren;
    logic        host_rden;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rdata;
    logic        nmi;
    logic        vbl_set;
    logic        vbl_clr;
    logic        spr0_hit;
    logic        spr_ovf;
    logic [7:0]  ctrl;
    logic [7:0]  mask;
    logic [14:0] taddr;
    logic [14:0] vaddr;
    logic [2:0]  fine_x;
    logic [7:0]  oam_addr;
    logic        oam_wren;
    logic [7:0]  oam_wdata;
    logic [7:0]  oam_rdata;
    logic [13:0] vram_addr;
    logic        vram_wren;
    logic        vram_rden;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_q;

    logic [7:0]  vram [0:16383];
    logic [7:0]  oam  [0:255];

    logic        sn_vw;
    logic        sn_vr;
    logic [13:0] sn_va;
    logic [7:0]  sn_vd;
    logic        sn_ow;
    logic [7:0]  sn_oa;
    logic [7:0]  sn_od;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;
    sb_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ppu_host_regs dut (
        .I_clock        (clk),
        .I_reset        (rst_n),
        .I_host_addr    (host_addr),
        .I_host_wren    (host_wren),
        .I_host_rden    (host_rden),
        .I_host_data    (host_wdata),
        .O_host_data    (host_rdata),
        .O_host_nmi     (nmi),
        .I_vblank_set   (vbl_set),
        .I_vblank_clear (vbl_clr),
        .I_spr0_hit     (spr0_hit),
        .I_spr_ovf      (spr_ovf),
        .O_ctrl         (ctrl),
        .O_mask         (mask),
        .O_taddr        (taddr),
        .O_vaddr        (vaddr),
        .O_fine_x       (fine_x),
        .O_oam_addr     (oam_addr),
        .O_oam_wren     (oam_wren),
        .O_oam_data     (oam_wdata),
        .I_oam_data     (oam_rdata),
        .O_vram_addr    (vram_addr),
        .O_vram_wren    (vram_wren),
        .O_vram_rden    (vram_rden),
        .O_vram_data    (vram_wdata),
        .I_vram_data    (vram_q)
    );

    // VRAM has one cycle of read latency; OAM reads combinationally.
    always @(posedge clk) begin
        if (vram_wren) vram[vram_addr] <= vram_wdata;
        if (vram_rden) vram_q <= vram[vram_addr];
        if (oam_wren)  oam[oam_addr] <= oam_wdata;
    end
    assign oam_rdata = oam[oam_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic op(input string tag, input logic [2:0] a, input logic wr, input logic rd,
                      input logic [7:0] d, input logic [7:0] exp);
        sb_t e;
        host_addr  = a;
        host_wren  = wr;
        host_rden  = rd;
        host_wdata = d;
        if (rd && !wr) begin
            e.tag = tag;
            e.exp = exp;
            sb.push_back(e);
        end
        #1;
        sn_vw = vram_wren;
        sn_vr = vram_rden;
        sn_va = vram_addr;
        sn_vd = vram_wdata;
        sn_ow = oam_wren;
        sn_oa = oam_addr;
        sn_od = oam_wdata;
        @(posedge clk);
        #1;
        host_wren = 1'b0;
        host_rden = 1'b0;
        if (rd && !wr) begin
            e = sb.pop_front();
            check(e.tag, host_rdata, e.exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        op("", a, 1'b1, 1'b0, d, 8'h00);
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
        op(tag, a, 1'b0, 1'b1, 8'h00, exp);
    endtask

    task automatic idle();
        op("", 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
        for (int i = 0; i < 256; i++) oam[i] = 8'(i) ^ 8'hA5;
        vram_q = 8'h00;
        rst_n = 1'b0;
        host_addr = 3'd0; host_wren = 1'b0; host_rden = 1'b0; host_wdata = 8'h00;
        vbl_set = 1'b0; vbl_clr = 1'b0; spr0_hit = 1'b0; spr_ovf = 1'b0;
        @(posedge clk); #1;
        idle(); idle(); idle();
        check("rst_host_data", host_rdata, 8'h00);
        check("rst_nmi", nmi, 1'b0);
        check("rst_vaddr", vaddr, 15'h0000);
        check("rst_ctrl", ctrl, 8'h00);
        check("rst_oam_addr", oam_addr, 8'h00);
        rst_n = 1'b1;

        // Address load and DATA writes with both increments
        wr(3'd6, 8'h21); wr(3'd6, 8'h08);
        check("addr_vaddr", vaddr, 15'h2108);
        check("addr_taddr", taddr, 15'h2108);
        wr(3'd7, 8'h55);
        check("dw_strobe", {sn_vw, sn_vr}, 2'b10);
        check("dw_addr", sn_va, 14'h2108);
        check("dw_data", sn_vd, 8'h55);
        check("dw_vinc1", vaddr, 15'h2109);
        wr(3'd0, 8'h04);
        wr(3'd7, 8'h66);
        check("dw32_addr", sn_va, 14'h2109);
        check("dw_vinc32", vaddr, 15'h2129);

        // Buffered reads with fill forwarding
        wr(3'd0, 8'h00);
        wr(3'd6, 8'h20); wr(3'd6, 8'h10); wr(3'd7, 8'h11);
        wr(3'd6, 8'h20); wr(3'd6, 8'h00); wr(3'd7, 8'hAA); wr(3'd7, 8'hBB);
        wr(3'd6, 8'h20); wr(3'd6, 8'h10);
        rd("rd_prime", 3'd7, 8'h00);
        idle();
        wr(3'd6, 8'h20); wr(3'd6, 8'h00);
        rd("rd_b2b0", 3'd7, 8'h11);
        check("rd_strobe", {sn_vw, sn_vr}, 2'b01);
        check("rd_addr", sn_va, 14'h2000);
        rd("rd_b2b1", 3'd7, 8'hAA);
        rd("rd_b2b2", 3'd7, 8'hBB);
        check("rd_vend", vaddr, 15'h2003);
        rd("open_bus", 3'd0, 8'hBB);

        // Scroll, with a STATUS read resetting the write toggle
        wr(3'd5, 8'h7D);
        rd("st_mid_scroll", 3'd2, 8'h1D);
        wr(3'd5, 8'h5E);
        check("scroll_reset_x", taddr[4:0], 5'h0B);
        check("scroll_reset_fx", fine_x, 3'd6);
        rd("st_pre_scroll", 3'd2, 8'h1E);
        wr(3'd5, 8'h7D); wr(3'd5, 8'h5E);
        check("scroll_cx", taddr[4:0], 5'h0F);
        check("scroll_fx", fine_x, 3'd5);
        check("scroll_fy", taddr[14:12], 3'd6);
        check("scroll_cy", taddr[9:5], 5'h0B);

        // Vblank race, NMI and sticky flags
        wr(3'd0, 8'h80);
        vbl_set = 1'b1;
        rd("st_race", 3'd2, 8'h00);
        vbl_set = 1'b0;
        check("nmi_race", nmi, 1'b0);
        rd("st_after_race", 3'd2, 8'h00);
        vbl_set = 1'b1; idle(); vbl_set = 1'b0;
        check("nmi_set", nmi, 1'b1);
        rd("st_vbl", 3'd2, 8'h80);
        check("nmi_drop", nmi, 1'b0);
        spr0_hit = 1'b1; idle(); spr0_hit = 1'b0;
        rd("st_spr0", 3'd2, 8'h40);
        vbl_clr = 1'b1; spr_ovf = 1'b1; idle(); vbl_clr = 1'b0; spr_ovf = 1'b0;
        rd("st_clr_prio", 3'd2, 8'h00);
        wr(3'd0, 8'h00);
        vbl_set = 1'b1; idle(); vbl_set = 1'b0;
        check("nmi_ctrl_off", nmi, 1'b0);
        wr(3'd0, 8'h80);
        check("nmi_ctrl_on", nmi, 1'b1);
        vbl_clr = 1'b1; idle(); vbl_clr = 1'b0;
        check("nmi_clr", nmi, 1'b0);

        // OAM wrap and read
        wr(3'd3, 8'hFF);
        wr(3'd4, 8'h3C);
        check("oam_wren", sn_ow, 1'b1);
        check("oam_waddr", sn_oa, 8'hFF);
        check("oam_wdata", sn_od, 8'h3C);
        check("oam_wrap", oam_addr, 8'h00);
        rd("oam_rd", 3'd4, 8'hA5);
        check("oam_rd_noinc", oam_addr, 8'h00);

        // Simultaneous write and read on DATA: write only
        op("", 3'd7, 1'b1, 1'b1, 8'h99, 8'h00);
        check("wr_wins_strobe", {sn_vw, sn_vr}, 2'b10);
        check("wr_wins_vinc", vaddr, 15'h2004);
        check("wr_wins_hold", host_rdata, 8'hA5);

        // Reset while a fill is pending
        wr(3'd6, 8'h20); wr(3'd6, 8'h03);
        rd("rd_prefill", 3'd7, 8'h00);
        rst_n = 1'b0;
        wr(3'd7, 8'h12);
        check("rst_strobe", {sn_vw, sn_vr}, 2'b00);
        check("rst_mid_host", host_rdata, 8'h00);
        check("rst_mid_vaddr", vaddr, 15'h0000);
        check("rst_mid_nmi", nmi, 1'b0);
        rst_n = 1'b1;
        rd("rd_postrst", 3'd7, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
